// File: rtl/modport_memory.sv
// Single-port 16x16 synchronous memory behind a valid/ready request handshake.
// Latency: a write is stored at the accepting edge; read data is registered at the accepting edge.
// Backpressure: ready_o is low through reset and for the first edge after it, and high from then on.
module modport_memory #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic                  wr_rd_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic                  ready_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             accept;
    logic             in_range;

    assign accept   = valid_i && ready_o;
    // Addresses past the last word only exist when DEPTH is not a power of two.
    assign in_range = ({1'b0, addr_i} < (ADDR_WIDTH+1)'(DEPTH));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data_o <= '0;
            ready_o   <= 1'b0;
        end else begin
            ready_o <= 1'b1;
            if (accept) begin
                if (wr_rd_i) begin
                    if (in_range) begin
                        mem[addr_i] <= wr_data_i;
                    end
                end else begin
                    rd_data_o <= in_range ? mem[addr_i] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_modport_memory.sv
// Randomized and directed bench for modport_memory against a behavioural array model.
module tb_modport_memory;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        wr_rd_i = 1'b0;
    logic [3:0]  addr_i = '0;
    logic [15:0] wr_data_i = '0;
    logic [15:0] rd_data_o;
    logic        ready_o;

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] ref_mem [16];
    logic [15:0] exp_rd  = '0;
    logic        exp_rdy = 1'b0;

    modport_memory dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .wr_rd_i   (wr_rd_i),
        .addr_i    (addr_i),
        .wr_data_i (wr_data_i),
        .rd_data_o (rd_data_o),
        .ready_o   (ready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: present a request, let the edge happen, update the model, compare.
    task automatic cycle(input logic r, input logic v, input logic w,
                         input logic [3:0] a, input logic [15:0] d);
        rst_i     = r;
        valid_i   = v;
        wr_rd_i   = w;
        addr_i    = a;
        wr_data_i = d;
        @(posedge clk_i);
        if (r) begin
            foreach (ref_mem[i]) ref_mem[i] = '0;
            exp_rd  = '0;
            exp_rdy = 1'b0;
        end else begin
            if (v && exp_rdy) begin
                if (w) ref_mem[a] = d;
                else   exp_rd = ref_mem[a];
            end
            exp_rdy = 1'b1;
        end
        #1;
        check("ready", {15'd0, ready_o}, {15'd0, exp_rdy});
        check("rd_data", rd_data_o, exp_rd);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'bx, 4'bxxxx, 16'hxxxx);
    endtask

    initial begin
        foreach (ref_mem[i]) ref_mem[i] = '0;

        // Reset, then two idle cycles
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 16'd0);
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 16'd0);
        check("rst_rd", rd_data_o, 16'h0000);
        check("rst_rdy", {15'd0, ready_o}, 16'd0);
        idle();
        check("rdy_after_rst", {15'd0, ready_o}, 16'd1);
        idle();

        // Write then read the next cycle
        cycle(1'b0, 1'b1, 1'b1, 4'd3, 16'hA5A5);
        cycle(1'b0, 1'b1, 1'b0, 4'd3, 16'h0000);
        check("wr_rd_a5", rd_data_o, 16'hA5A5);

        // Back-to-back fill and readback
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b1, 4'(i), 16'(i * 16'h1111));
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 4'(i), 16'h0000);
            check("fill", rd_data_o, 16'(i * 16'h1111));
        end
        idle();
        check("hold", rd_data_o, 16'hFFFF);

        // Fresh reset: unwritten word reads zero; first post-reset request is refused
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 16'd0);
        cycle(1'b0, 1'b1, 1'b1, 4'd9, 16'h7777);
        check("first_rdy", {15'd0, ready_o}, 16'd1);
        cycle(1'b0, 1'b1, 1'b0, 4'd7, 16'h0000);
        check("rd7_clear", rd_data_o, 16'h0000);
        cycle(1'b0, 1'b1, 1'b0, 4'd9, 16'h0000);
        check("rd9_refused", rd_data_o, 16'h0000);

        // Write, reset with a write presented, then read both back
        cycle(1'b0, 1'b1, 1'b1, 4'd5, 16'h1234);
        cycle(1'b0, 1'b1, 1'b0, 4'd5, 16'h0000);
        check("rd5_pre", rd_data_o, 16'h1234);
        cycle(1'b1, 1'b1, 1'b1, 4'd6, 16'h5555);
        check("mid_rst_rd", rd_data_o, 16'h0000);
        idle();
        cycle(1'b0, 1'b1, 1'b0, 4'd5, 16'h0000);
        check("rd5_post", rd_data_o, 16'h0000);
        cycle(1'b0, 1'b1, 1'b1, 4'd4, 16'hCAFE);
        cycle(1'b0, 1'b1, 1'b0, 4'd4, 16'h0000);
        cycle(1'b0, 1'b1, 1'b0, 4'd6, 16'h0000);
        check("rd6_rst_wr", rd_data_o, 16'h0000);

        // Write-shaped request with valid low is ignored
        cycle(1'b0, 1'b1, 1'b0, 4'd4, 16'h0000);
        cycle(1'b0, 1'b0, 1'b1, 4'd2, 16'hBEEF);
        check("idle_hold", rd_data_o, 16'hCAFE);
        cycle(1'b0, 1'b1, 1'b0, 4'd2, 16'h0000);
        check("rd2_novalid", rd_data_o, 16'h0000);

        // Random traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                  4'($urandom), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
